// File: rtl/seq_comparator_if.sv
// rtl/seq_comparator_if.sv - operand/result handshake bundle for seq_comparator
interface seq_comparator_if #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] porta;
  logic [WIDTH-1:0] portb;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             equal;
  logic             less;
  logic             higher;
  logic [CW-1:0]    cycles;

  modport master (
    output in_valid, porta, portb, signed_mode, out_ready,
    input  in_ready, out_valid, equal, less, higher, cycles
  );

  modport slave (
    input  in_valid, porta, portb, signed_mode, out_ready,
    output in_ready, out_valid, equal, less, higher, cycles
  );
endinterface

// File: rtl/seq_comparator.sv
// rtl/seq_comparator.sv - multi-cycle MSB-first digit-serial magnitude comparator
module seq_comparator #(
  parameter int WIDTH     = 8,
  parameter int DIGIT     = 2,
  parameter int SIGNED_EN = 1
) (
  input logic          clk,
  input logic          rst_n,
  seq_comparator_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [DIGIT-1:0] da;
  logic [DIGIT-1:0] db;

  // Flipping the sign bit maps two's complement onto unsigned ordering.
  always_comb begin
    a_in = bus.porta;
    b_in = bus.portb;
    if (bus.signed_mode && (SIGNED_EN != 0)) begin
      a_in[WIDTH-1] = ~bus.porta[WIDTH-1];
      b_in[WIDTH-1] = ~bus.portb[WIDTH-1];
    end
  end

  // Operands shift left each step, so the current digit is always the top slice.
  assign da = a_q[WIDTH-1 -: DIGIT];
  assign db = b_q[WIDTH-1 -: DIGIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      a_q           <= '0;
      b_q           <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.equal     <= 1'b0;
      bus.less      <= 1'b0;
      bus.higher    <= 1'b0;
      bus.cycles    <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            a_q          <= a_in;
            b_q          <= b_in;
            idx          <= '0;
            bus.in_ready <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          if (da != db) begin
            bus.less      <= (da < db);
            bus.higher    <= (da > db);
            bus.cycles    <= CW'(idx) + CW'(1);
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else if (idx == LAST) begin
            bus.equal     <= 1'b1;
            bus.cycles    <= CW'(N);
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            idx <= idx + IW'(1);
            a_q <= a_q << DIGIT;
            b_q <= b_q << DIGIT;
          end
        end
        DONE: begin
          // in_ready comes up at the handshake edge so the next accept is one cycle later.
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.equal     <= 1'b0;
            bus.less      <= 1'b0;
            bus.higher    <= 1'b0;
            bus.cycles    <= '0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule
